cache_controller_2way_param: RTL and testbench

- Parametrised 2-way set-associative, write-through, no-write-allocate cache between the MEM stage and the SRAM controller.
- Each line is one two-word block (2*DATA_W), filled by a single SRAM read.
- Successor to the fixed-geometry cache controller. Adds a configurable set count, true LRU, a flush/invalidate input and optional hit/miss statistics.
- The MEM stage freezes on ready=0 and holds its request stable until ready=1.

---
 rtl/cache_controller_2way_param_if.sv | 43 ++++
 rtl/cache_controller_2way_param.sv | 235 +++++++++++++++++++++++
 tb/tb_cache_controller_2way_param.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_controller_2way_param_if.sv
// Bus bundle between the MEM stage, the 2-way cache controller and the SRAM
// controller. The cache is the slave of this bundle; whoever drives the MEM
// requests and answers the SRAM side (pipeline plus SRAM controller, or a
// bench) is the master.
interface cache_controller_2way_param_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STAT_W = 32
) ();

  logic [ADDR_W-1:0]   address;
  logic [DATA_W-1:0]   writeData;
  logic                MEM_R_EN;
  logic                MEM_W_EN;
  logic                flush;
  logic [DATA_W-1:0]   rdata;
  logic                ready;
  logic [ADDR_W-1:0]   sram_address;
  logic [DATA_W-1:0]   sram_write_data;
  logic                sram_read_en;
  logic                sram_write_en;
  logic [2*DATA_W-1:0] sram_read_data;
  logic                sram_ready;
  logic [STAT_W-1:0]   hit_count;
  logic [STAT_W-1:0]   miss_count;

  modport slave (
    input  address, writeData, MEM_R_EN, MEM_W_EN, flush,
    input  sram_read_data, sram_ready,
    output rdata, ready,
    output sram_address, sram_write_data, sram_read_en, sram_write_en,
    output hit_count, miss_count
  );

  modport master (
    output address, writeData, MEM_R_EN, MEM_W_EN, flush,
    output sram_read_data, sram_ready,
    input  rdata, ready,
    input  sram_address, sram_write_data, sram_read_en, sram_write_en,
    input  hit_count, miss_count
  );

endinterface

// File: rtl/cache_controller_2way_param.sv
// Parametrised 2-way set-associative, write-through, no-write-allocate cache
// sitting between the MEM stage and the SRAM controller. Each line holds one
// two-word block fetched with a single SRAM read; one LRU bit per set names
// the way to evict next. Read hits complete in the request cycle, misses and
// all writes go through the SRAM.
// Optional hit/miss statistics are built only when the macro CACHE_STATS_EN
// is defined; otherwise hit_count/miss_count are constant zero.
module cache_controller_2way_param #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int SET_BITS = 6,
  parameter int STAT_W   = 32
) (
  input  logic clk,
  input  logic rst,
  cache_controller_2way_param_if.slave bus
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = ADDR_W - SET_BITS - 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE
  } state_t;

  state_t state;
  state_t next_state;

  // Address decomposition: bit 2 picks the word inside the block, bits 1:0
  // are byte offsets the cache never looks at.
  logic [SET_BITS-1:0] index;
  logic [TAG_W-1:0]    tag;
  logic                word_sel;
  logic                unused_addr_bits;

  assign index            = bus.address[SET_BITS+2:3];
  assign tag              = bus.address[ADDR_W-1:SET_BITS+3];
  assign word_sel         = bus.address[2];
  assign unused_addr_bits = ^bus.address[1:0];

  // Line storage. Valid and LRU bits are reset; tags and data need not be,
  // because nothing reads them while the valid bit is clear.
  logic [SETS-1:0]     valid0;
  logic [SETS-1:0]     valid1;
  logic [SETS-1:0]     lru;
  logic [TAG_W-1:0]    tag_mem  [2][SETS];
  logic [2*DATA_W-1:0] data_mem [2][SETS];
  logic                flush_pending;

  logic                hit0;
  logic                hit1;
  logic                hit;
  logic                hit_way;
  logic [2*DATA_W-1:0] hit_block;
  logic                fill_way;

  logic                is_write;
  logic                is_read;
  logic                read_hit_idle;
  logic                write_hit_idle;
  logic                fill_done;
  logic                leave_busy;
  logic                apply_flush;

  function automatic logic [DATA_W-1:0] pick_word(input logic [2*DATA_W-1:0] blk,
                                                  input logic sel);
    return sel ? blk[2*DATA_W-1:DATA_W] : blk[DATA_W-1:0];
  endfunction

  // Tag compare only ever looks at the indexed set. A tag can live in at most
  // one way because fills only happen after a miss, so way 1 is the hit way
  // exactly when way 0 did not match.
  assign hit0      = valid0[index] && (tag_mem[0][index] == tag);
  assign hit1      = valid1[index] && (tag_mem[1][index] == tag);
  assign hit       = hit0 | hit1;
  assign hit_way   = hit1 & ~hit0;
  assign hit_block = data_mem[hit_way][index];

  // Victim choice: an empty way 0, then an empty way 1, otherwise the LRU way.
  assign fill_way = !valid0[index] ? 1'b0 :
                    (!valid1[index] ? 1'b1 : lru[index]);

  // A simultaneous load and store request is handled as a store.
  assign is_write       = bus.MEM_W_EN;
  assign is_read        = bus.MEM_R_EN & ~bus.MEM_W_EN;
  assign read_hit_idle  = (state == S_IDLE) && is_read && hit;
  assign write_hit_idle = (state == S_IDLE) && is_write && hit;
  assign fill_done      = (state == S_READ) && bus.sram_ready;
  assign leave_busy     = (state != S_IDLE) && bus.sram_ready;

  // A flush seen while idle acts at the next edge; one seen (or remembered)
  // during an SRAM transaction acts on the edge that returns to idle, after
  // the fill, so the freshly filled line is dropped too.
  assign apply_flush = ((state == S_IDLE) && bus.flush) ||
                       (leave_busy && (flush_pending || bus.flush));

  // State register; reset always lands in idle, abandoning any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and every output; idle with no request answers ready with zero data.
  always_comb begin
    next_state          = state;
    bus.ready           = 1'b0;
    bus.rdata           = '0;
    bus.sram_address    = '0;
    bus.sram_write_data = '0;
    bus.sram_read_en    = 1'b0;
    bus.sram_write_en   = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (is_write) begin
          next_state = S_WRITE;
        end else if (is_read) begin
          if (hit) begin
            bus.ready = 1'b1;
            bus.rdata = pick_word(hit_block, word_sel);
          end else begin
            next_state = S_READ;
          end
        end else begin
          bus.ready = 1'b1;
        end
      end

      S_READ: begin
        bus.sram_read_en = 1'b1;
        bus.sram_address = {bus.address[ADDR_W-1:3], 3'b000};
        if (bus.sram_ready) begin
          bus.ready  = 1'b1;
          bus.rdata  = pick_word(bus.sram_read_data, word_sel);
          next_state = S_IDLE;
        end
      end

      S_WRITE: begin
        bus.sram_write_en   = 1'b1;
        bus.sram_address    = bus.address;
        bus.sram_write_data = bus.writeData;
        if (bus.sram_ready) begin
          bus.ready  = 1'b1;
          next_state = S_IDLE;
        end
      end

      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Valid, LRU and pending-flush bookkeeping; a flush overrides a same-edge fill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid0        <= '0;
      valid1        <= '0;
      lru           <= '0;
      flush_pending <= 1'b0;
    end else begin
      if (read_hit_idle || write_hit_idle) begin
        lru[index] <= ~hit_way;
      end

      if (fill_done) begin
        if (fill_way) begin
          valid1[index] <= 1'b1;
        end else begin
          valid0[index] <= 1'b1;
        end
        lru[index] <= ~fill_way;
      end

      if (leave_busy) begin
        flush_pending <= 1'b0;
      end else if ((state != S_IDLE) && bus.flush) begin
        flush_pending <= 1'b1;
      end

      if (apply_flush) begin
        valid0 <= '0;
        valid1 <= '0;
      end
    end
  end

  // Tag and data arrays: whole-block fill on a read miss, single-word update on a store hit.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_mem[fill_way][index]  <= tag;
      data_mem[fill_way][index] <= bus.sram_read_data;
    end
    if (write_hit_idle) begin
      if (word_sel) begin
        data_mem[hit_way][index][2*DATA_W-1:DATA_W] <= bus.writeData;
      end else begin
        data_mem[hit_way][index][DATA_W-1:0] <= bus.writeData;
      end
    end
  end

`ifdef CACHE_STATS_EN
  logic [STAT_W-1:0] hit_q;
  logic [STAT_W-1:0] miss_q;

  // Read hits served from idle and completed fills; rst clears them, flush does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (read_hit_idle) begin
        hit_q <= hit_q + STAT_W'(1);
      end
      if (fill_done) begin
        miss_q <= miss_q + STAT_W'(1);
      end
    end
  end

  assign bus.hit_count  = hit_q;
  assign bus.miss_count = miss_q;
`else
  assign bus.hit_count  = '0;
  assign bus.miss_count = '0;
`endif

endmodule

// File: tb/tb_cache_controller_2way_param.sv
// Self-checking bench for cache_controller_2way_param: a directed vector table
// for the main cache scenarios, hand sequences for reset and statistics, and
// a randomized phase checked against a recency-list cache model and a word
// memory that also plays the SRAM controller.
module tb_cache_controller_2way_param;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int SET_BITS = 6;
  localparam int STAT_W   = 32;
  localparam int BUDGET   = 20;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cache_controller_2way_param_if #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STAT_W(STAT_W)
  ) bus ();

  cache_controller_2way_param #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .SET_BITS(SET_BITS),
    .STAT_W  (STAT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  typedef enum int {K_IDLE, K_HIT, K_MISS, K_WRITE} kind_t;

  typedef struct packed {
    logic        first_ready;
    logic [31:0] first_rdata;
    logic        saw_rd;
    logic        saw_wr;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        done_ready;
    logic [31:0] done_rdata;
    logic        early_ready;
    logic        timeout;
  } obs_t;

  typedef struct {
    string       name;
    logic        r;
    logic        w;
    logic        f;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    int          flush_at;
    kind_t       kind;
    logic [31:0] word;
  } vec_t;

  // Backing store, word addressed; unwritten words follow a fixed pattern.
  logic [31:0] mem [int unsigned];

  function automatic logic [31:0] memRead(input logic [31:0] waddr);
    if (mem.exists(waddr)) return mem[waddr];
    return (waddr * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Cache model: list of resident lines, most recently used first. A set
  // holds at most two lines; the oldest one of a set is the victim.
  typedef struct packed {
    logic [31:0] set_idx;
    logic [31:0] tag;
  } line_t;

  line_t lines[$];
  int    model_hits;
  int    model_misses;

  function automatic logic [31:0] setOf(input logic [31:0] a);
    return (a >> 3) & ((32'd1 << SET_BITS) - 32'd1);
  endfunction

  function automatic logic [31:0] tagOf(input logic [31:0] a);
    return a >> (SET_BITS + 3);
  endfunction

  function automatic int findLine(input logic [31:0] a);
    for (int i = 0; i < lines.size(); i++) begin
      if (lines[i].set_idx == setOf(a) && lines[i].tag == tagOf(a)) return i;
    end
    return -1;
  endfunction

  function automatic void touchLine(input logic [31:0] a);
    int    pos;
    int    n;
    line_t l;
    pos = findLine(a);
    n   = 0;
    if (pos >= 0) lines.delete(pos);
    l.set_idx = setOf(a);
    l.tag     = tagOf(a);
    lines.push_front(l);
    for (int j = 0; j < lines.size(); j++) begin
      if (lines[j].set_idx == l.set_idx) begin
        n++;
        if (n > 2) begin
          lines.delete(j);
          break;
        end
      end
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Presents one MEM request and plays the SRAM controller until ready.
  task automatic applyStimulus(input logic r, input logic w, input logic f,
                               input logic [31:0] a, input logic [31:0] d,
                               input int lat, input int flush_at, output obs_t o);
    int          cyc;
    bit          done;
    logic [31:0] base;
    o    = '0;
    cyc  = 0;
    @(negedge clk);
    bus.address    = a;
    bus.writeData  = d;
    bus.MEM_R_EN   = r;
    bus.MEM_W_EN   = w;
    bus.flush      = f;
    bus.sram_ready = 1'b0;
    #1;
    o.first_ready = bus.ready;
    o.first_rdata = bus.rdata;
    o.saw_rd      = bus.sram_read_en;
    o.saw_wr      = bus.sram_write_en;
    done          = bus.ready;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    while (!done && cyc < BUDGET) begin
      @(negedge clk);
      bus.flush = (cyc == flush_at);
      #1;
      if (bus.sram_read_en) begin
        o.saw_rd    = 1'b1;
        o.sram_addr = bus.sram_address;
      end
      if (bus.sram_write_en) begin
        o.saw_wr     = 1'b1;
        o.sram_addr  = bus.sram_address;
        o.sram_wdata = bus.sram_write_data;
      end
      if (bus.ready) o.early_ready = 1'b1;
      if (cyc == lat) begin
        base = {bus.sram_address[31:3], 3'b000} >> 2;
        bus.sram_read_data = {memRead(base + 32'd1), memRead(base)};
        bus.sram_ready     = 1'b1;
        #1;
        o.done_ready = bus.ready;
        o.done_rdata = bus.rdata;
        done         = 1'b1;
      end
      @(posedge clk);
      #1;
      bus.sram_ready = 1'b0;
      bus.flush      = 1'b0;
      cyc++;
    end
    if (!done) o.timeout = 1'b1;
    bus.MEM_R_EN = 1'b0;
    bus.MEM_W_EN = 1'b0;
  endtask

  task automatic checkObs(input string name, input kind_t kind, input logic [31:0] word,
                          input logic [31:0] a, input logic [31:0] d, input obs_t o);
    checkOutput({name, ".timeout"}, 32'(o.timeout), 32'd0);
    case (kind)
      K_IDLE: begin
        checkOutput({name, ".ready"}, 32'(o.first_ready), 32'd1);
        checkOutput({name, ".rdata"}, o.first_rdata, 32'd0);
      end
      K_HIT: begin
        checkOutput({name, ".hit_ready"}, 32'(o.first_ready), 32'd1);
        checkOutput({name, ".hit_rdata"}, o.first_rdata, word);
        checkOutput({name, ".no_sram_rd"}, 32'(o.saw_rd), 32'd0);
      end
      K_MISS: begin
        checkOutput({name, ".miss_ready0"}, 32'(o.first_ready), 32'd0);
        checkOutput({name, ".sram_rd"}, 32'(o.saw_rd), 32'd1);
        checkOutput({name, ".sram_addr"}, o.sram_addr, a & ~32'd7);
        checkOutput({name, ".early"}, 32'(o.early_ready), 32'd0);
        checkOutput({name, ".fill_ready"}, 32'(o.done_ready), 32'd1);
        checkOutput({name, ".fill_rdata"}, o.done_rdata, word);
      end
      default: begin
        checkOutput({name, ".wr_ready0"}, 32'(o.first_ready), 32'd0);
        checkOutput({name, ".sram_wr"}, 32'(o.saw_wr), 32'd1);
        checkOutput({name, ".no_sram_rd"}, 32'(o.saw_rd), 32'd0);
        checkOutput({name, ".sram_addr"}, o.sram_addr, a);
        checkOutput({name, ".sram_wdata"}, o.sram_wdata, d);
        checkOutput({name, ".early"}, 32'(o.early_ready), 32'd0);
        checkOutput({name, ".wr_ready"}, 32'(o.done_ready), 32'd1);
      end
    endcase
  endtask

  // One operation: predict from the model, run it, check, advance the model.
  // With has_exp the directed-table values are the expectation instead.
  task automatic runOp(input string name, input logic r, input logic w, input logic f,
                       input logic [31:0] a, input logic [31:0] d,
                       input int lat, input int flush_at,
                       input bit has_exp, input kind_t tkind, input logic [31:0] tword);
    kind_t       mkind;
    logic [31:0] mword;
    obs_t        o;
    if (w) mkind = K_WRITE;
    else if (r) mkind = (findLine(a) >= 0) ? K_HIT : K_MISS;
    else mkind = K_IDLE;
    mword = (mkind == K_IDLE) ? 32'd0 : memRead(a >> 2);

    applyStimulus(r, w, f, a, d, lat, flush_at, o);
    if (has_exp) checkObs(name, tkind, tword, a, d, o);
    else checkObs(name, mkind, mword, a, d, o);

    if (mkind == K_HIT) begin
      touchLine(a);
      model_hits++;
      if (f) lines.delete();
    end else begin
      if (f) lines.delete();
      if (mkind == K_MISS) begin
        touchLine(a);
        model_misses++;
      end
      if (mkind == K_WRITE) begin
        if (findLine(a) >= 0) touchLine(a);
        mem[a >> 2] = d;
      end
      if (mkind != K_IDLE && flush_at >= 0 && flush_at <= lat) lines.delete();
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst            = 1'b1;
    bus.MEM_R_EN   = 1'b0;
    bus.MEM_W_EN   = 1'b0;
    bus.flush      = 1'b0;
    bus.sram_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    lines.delete();
    model_hits   = 0;
    model_misses = 0;
  endtask

  function automatic logic [31:0] statExp(input int n);
`ifdef CACHE_STATS_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n - n);
`endif
  endfunction

  vec_t vecs [20];

  initial begin
    logic        r;
    logic        w;
    logic        f;
    logic [31:0] a;
    logic [31:0] d;
    int          sel;
    int          lat;
    int          fat;

    rst                = 1'b1;
    bus.address        = '0;
    bus.writeData      = '0;
    bus.MEM_R_EN       = 1'b0;
    bus.MEM_W_EN       = 1'b0;
    bus.flush          = 1'b0;
    bus.sram_read_data = '0;
    bus.sram_ready     = 1'b0;
    model_hits         = 0;
    model_misses       = 0;

    mem[32'h408 >> 2] = 32'hAAAA_AAAA;
    mem[32'h40C >> 2] = 32'hBBBB_BBBB;
    mem[32'h608 >> 2] = 32'h6666_6666;
    mem[32'h60C >> 2] = 32'h6767_6767;
    mem[32'h808 >> 2] = 32'h8888_8888;
    mem[32'h80C >> 2] = 32'h8989_8989;
    mem[32'hA08 >> 2] = 32'hA0A0_A0A0;

    vecs[0]  = '{"cold_rd_408",      1, 0, 0, 32'h408, 32'h0,         2, -1, K_MISS,  32'hAAAA_AAAA};
    vecs[1]  = '{"hit_rd_40C",       1, 0, 0, 32'h40C, 32'h0,         0, -1, K_HIT,   32'hBBBB_BBBB};
    vecs[2]  = '{"fill_608",         1, 0, 0, 32'h608, 32'h0,         0, -1, K_MISS,  32'h6666_6666};
    vecs[3]  = '{"hit_408",          1, 0, 0, 32'h408, 32'h0,         0, -1, K_HIT,   32'hAAAA_AAAA};
    vecs[4]  = '{"miss_808",         1, 0, 0, 32'h808, 32'h0,         1, -1, K_MISS,  32'h8888_8888};
    vecs[5]  = '{"hit_408_kept",     1, 0, 0, 32'h408, 32'h0,         0, -1, K_HIT,   32'hAAAA_AAAA};
    vecs[6]  = '{"miss_608_evicted", 1, 0, 0, 32'h608, 32'h0,         1, -1, K_MISS,  32'h6666_6666};
    vecs[7]  = '{"wr_408",           0, 1, 0, 32'h408, 32'h1234_5678, 3, -1, K_WRITE, 32'h0};
    vecs[8]  = '{"rd_408_new",       1, 0, 0, 32'h408, 32'h0,         0, -1, K_HIT,   32'h1234_5678};
    vecs[9]  = '{"wr_A08_miss",      0, 1, 0, 32'hA08, 32'hCAFE_F00D, 1, -1, K_WRITE, 32'h0};
    vecs[10] = '{"rd_A08_noalloc",   1, 0, 0, 32'hA08, 32'h0,         1, -1, K_MISS,  32'hCAFE_F00D};
    vecs[11] = '{"flush_idle",       0, 0, 1, 32'h0,   32'h0,         0, -1, K_IDLE,  32'h0};
    vecs[12] = '{"rd_408_flushed",   1, 0, 0, 32'h408, 32'h0,         2, -1, K_MISS,  32'h1234_5678};
    vecs[13] = '{"wr_40C_flush_mid", 0, 1, 0, 32'h40C, 32'h0BAD_BEEF, 2,  1, K_WRITE, 32'h0};
    vecs[14] = '{"rd_40F_after",     1, 0, 0, 32'h40F, 32'h0,         0, -1, K_MISS,  32'h0BAD_BEEF};
    vecs[15] = '{"hit_40B",          1, 0, 0, 32'h40B, 32'h0,         0, -1, K_HIT,   32'h1234_5678};
    vecs[16] = '{"rw_both_410",      1, 1, 0, 32'h410, 32'h55AA_55AA, 0, -1, K_WRITE, 32'h0};
    vecs[17] = '{"rd_410_noalloc",   1, 0, 0, 32'h410, 32'h0,         1, -1, K_MISS,  32'h55AA_55AA};
    vecs[18] = '{"rd_hit_with_flush",1, 0, 1, 32'h410, 32'h0,         0, -1, K_HIT,   32'h55AA_55AA};
    vecs[19] = '{"rd_410_after",     1, 0, 0, 32'h410, 32'h0,         0, -1, K_MISS,  32'h55AA_55AA};

    #1;
    checkOutput("reset.ready", 32'(bus.ready), 32'd1);
    checkOutput("reset.rdata", bus.rdata, 32'd0);
    checkOutput("reset.sram_read_en", 32'(bus.sram_read_en), 32'd0);
    checkOutput("reset.sram_write_en", 32'(bus.sram_write_en), 32'd0);
    checkOutput("reset.sram_address", bus.sram_address, 32'd0);
    checkOutput("reset.hit_count", bus.hit_count, 32'd0);
    checkOutput("reset.miss_count", bus.miss_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed vector table");
    for (int i = 0; i < 20; i++) begin
      runOp(vecs[i].name, vecs[i].r, vecs[i].w, vecs[i].f, vecs[i].addr, vecs[i].wdata,
            vecs[i].lat, vecs[i].flush_at, 1'b1, vecs[i].kind, vecs[i].word);
    end

    $display("[TB] reset in the middle of a fill");
    doReset();
    runOp("rst.pre_fill_408", 1, 0, 0, 32'h408, 32'h0, 1, -1, 1'b0, K_IDLE, 32'h0);
    @(negedge clk);
    bus.address  = 32'h608;
    bus.MEM_R_EN = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst.in_read_en", 32'(bus.sram_read_en), 32'd1);
    rst          = 1'b1;
    bus.MEM_R_EN = 1'b0;
    #1;
    checkOutput("rst.read_en_drop", 32'(bus.sram_read_en), 32'd0);
    checkOutput("rst.ready", 32'(bus.ready), 32'd1);
    checkOutput("rst.sram_address", bus.sram_address, 32'd0);
    checkOutput("rst.rdata", bus.rdata, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    lines.delete();
    model_hits   = 0;
    model_misses = 0;
    checkOutput("rst.hit_count_clr", bus.hit_count, 32'd0);
    checkOutput("rst.miss_count_clr", bus.miss_count, 32'd0);
    bus.sram_read_data = 64'hDEAD_DEAD_DEAD_DEAD;
    bus.sram_ready     = 1'b1;
    #1;
    checkOutput("rst.late_ready", 32'(bus.ready), 32'd1);
    checkOutput("rst.late_rdata", bus.rdata, 32'd0);
    @(posedge clk);
    #1;
    bus.sram_ready = 1'b0;
    @(negedge clk);
    #1;
    checkOutput("rst.still_idle", 32'(bus.sram_read_en), 32'd0);
    runOp("rst.line_gone_408", 1, 0, 0, 32'h408, 32'h0, 0, -1, 1'b1, K_MISS, memRead(32'h408 >> 2));

    $display("[TB] statistics sequence");
    doReset();
    runOp("stat.m1", 1, 0, 0, 32'h408, 32'h0, 1, -1, 1'b0, K_IDLE, 32'h0);
    runOp("stat.h1", 1, 0, 0, 32'h40C, 32'h0, 0, -1, 1'b0, K_IDLE, 32'h0);
    runOp("stat.m2", 1, 0, 0, 32'h608, 32'h0, 2, -1, 1'b0, K_IDLE, 32'h0);
    runOp("stat.h2", 1, 0, 0, 32'h60C, 32'h0, 0, -1, 1'b0, K_IDLE, 32'h0);
    runOp("stat.m3", 1, 0, 0, 32'h808, 32'h0, 0, -1, 1'b0, K_IDLE, 32'h0);
    @(negedge clk);
    #1;
    checkOutput("stat.hit_count", bus.hit_count, statExp(2));
    checkOutput("stat.miss_count", bus.miss_count, statExp(3));

    $display("[TB] randomized phase");
    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(99);
      lat = $urandom_range(3);
      fat = -1;
      r   = 1'b0;
      w   = 1'b0;
      f   = 1'b0;
      d   = $urandom;
      a   = (32'($urandom_range(7)) << (SET_BITS + 3)) | (32'($urandom_range(2)) << 3) |
            32'($urandom_range(7));
      if (sel < 55) begin
        r = 1'b1;
      end else if (sel < 80) begin
        w = 1'b1;
        r = ($urandom_range(9) == 0);
      end else if (sel < 90) begin
        f = 1'b1;
      end else if (sel < 95) begin
        f = 1'b0;
      end else begin
        r = 1'b1;
        f = 1'b1;
      end
      if ((r || w) && $urandom_range(6) == 0) fat = $urandom_range(lat);
      runOp($sformatf("rnd%0d", n), r, w, f, a, d, lat, fat, 1'b0, K_IDLE, 32'h0);
    end

    @(negedge clk);
    #1;
    checkOutput("final.hit_count", bus.hit_count, statExp(model_hits));
    checkOutput("final.miss_count", bus.miss_count, statExp(model_misses));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
